// File: rtl/down_counter_reload.sv
// Loadable down counter with terminal-count pulse, one-shot and auto-reload modes.
// Optional macro DOWN_COUNTER_WRAP_CNT_EN adds a wrap_cnt output counting tc pulses.
module down_counter_reload #(
  parameter int W      = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [W-1:0]      load_val,
  input  logic              en,
  input  logic              auto_reload,
  output logic [W-1:0]      count,
  output logic              zero,
  output logic              tc,
`ifdef DOWN_COUNTER_WRAP_CNT_EN
  output logic [WRAP_W-1:0] wrap_cnt,
`endif
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] reload_reg;

  assign zero = (count == '0);
  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      state      <= IDLE;
    end else if (load) begin
      count      <= load_val;
      reload_reg <= load_val;
      tc         <= 1'b0;
      state      <= (load_val != '0) ? RUN : DONE;
    end else if (en && (state == RUN)) begin
      if (count > W'(1)) begin
        count <= count - W'(1);
        tc    <= 1'b0;
      end else if (count == W'(1)) begin
        count <= '0;
        tc    <= 1'b1;
        // auto_reload only matters at the moment the count reaches zero
        state <= auto_reload ? RUN : DONE;
      end else begin
        count <= reload_reg;
        tc    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

`ifdef DOWN_COUNTER_WRAP_CNT_EN
  // Counts cycles with tc high; a load restarts the tally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_cnt <= '0;
    end else if (load) begin
      wrap_cnt <= '0;
    end else if (tc) begin
      wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_down_counter_reload.sv
// Bench for down_counter_reload: vector table, corner sequences, random run vs model.
module tb_down_counter_reload;
  localparam int W      = 3;
  localparam int WRAP_W = 8;
  localparam int MAXV   = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         zero;
  logic         tc;
  logic         busy;
`ifdef DOWN_COUNTER_WRAP_CNT_EN
  logic [WRAP_W-1:0] wrap_cnt;
`endif

  down_counter_reload #(.W(W), .WRAP_W(WRAP_W)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .en(en),
    .auto_reload(auto_reload),
    .count(count),
    .zero(zero),
    .tc(tc),
`ifdef DOWN_COUNTER_WRAP_CNT_EN
    .wrap_cnt(wrap_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining count, last loaded value, running flag.
  int m_count, m_reload, m_tc, m_wrap;
  bit m_run;

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_tc = 0; m_wrap = 0; m_run = 0;
  endtask

  task automatic model_step(input bit ld, input int lv, input bit e, input bit ar);
    int old_tc;
    old_tc = m_tc;
    if (ld) begin
      m_count = lv; m_reload = lv; m_tc = 0; m_run = (lv != 0);
      m_wrap = 0;
    end else begin
      m_wrap = (m_wrap + old_tc) % (1 << WRAP_W);
      if (e && m_run) begin
        if (m_count == 0) begin
          m_count = m_reload; m_tc = 0;
        end else begin
          m_count = m_count - 1;
          m_tc = (m_count == 0);
          if (m_tc && !ar) m_run = 0;
        end
      end else begin
        m_tc = 0;
      end
    end
  endtask

  // Drive on the falling edge, advance one rising edge, sample 1 ns later.
  task automatic step(input bit ld, input int lv, input bit e, input bit ar);
    @(negedge clk);
    load = ld; load_val = W'(lv); en = e; auto_reload = ar;
    @(posedge clk);
    model_step(ld, lv, e, ar);
    #1;
  endtask

  typedef struct {
    bit ld; int lv; bit e; bit ar;
    int exp_count; bit exp_tc; bit exp_busy;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];
  int tc_seen;

  initial begin
    // one-shot 5 down to 0, then hold in DONE
    vecs.push_back('{1, 5, 1, 0, 5, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 3, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 2, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 0, 1, 0});
    for (int i = 0; i < 5; i++) vecs.push_back('{0, 0, 1, 0, 0, 0, 0});
    // enable gating
    vecs.push_back('{1, 6, 0, 0, 6, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 5, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 5, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 5, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 3, 0, 1});

    load = 0; load_val = '0; en = 0; auto_reload = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check("reset_count", count, 0);
    check("reset_zero", zero, 1);
    check("reset_tc", tc, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1);
      check("idle_count", count, 0);
      check("idle_busy", busy, 0);
      check("idle_tc", tc, 0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].e, vecs[i].ar);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_count == 0);
    end

    // auto-reload, full-range period of 8
    step(1, 7, 1, 1);
    check("ar_load", count, 7);
    for (int k = 1; k <= 24; k++) begin
      step(0, 0, 1, 1);
      check("ar_count", count, (7 - k) & MAXV);
      check("ar_tc", tc, ((7 - k) & MAXV) == 0);
      check("ar_busy", busy, 1);
    end
`ifdef DOWN_COUNTER_WRAP_CNT_EN
    check("ar_wrap_cnt", wrap_cnt, 3);
`endif

    // load beats en mid-run; no decrement that cycle
    tc_seen = 0;
    step(1, 4, 1, 0); check("ld_pri_4", count, 4);
    step(0, 0, 1, 0); check("ld_pri_3", count, 3);
    step(0, 0, 1, 0); check("ld_pri_2", count, 2);
    step(1, 2, 1, 0); check("ld_pri_reload", count, 2);
    check("ld_pri_tc0", tc, 0);
    step(0, 0, 1, 0); check("ld_pri_1", count, 1); tc_seen += tc;
    step(0, 0, 1, 0); check("ld_pri_0", count, 0); tc_seen += tc;
    step(0, 0, 1, 0); check("ld_pri_hold", count, 0); tc_seen += tc;
    check("ld_pri_tc_once", tc_seen, 1);
    check("ld_pri_done_busy", busy, 0);

    // load of zero goes straight to DONE
    step(1, 0, 1, 1);
    check("ld0_count", count, 0);
    check("ld0_zero", zero, 1);
    check("ld0_busy", busy, 0);
    check("ld0_tc", tc, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      check("ld0_tc_hold", tc, 0);
    end

    // asynchronous reset mid-run
    step(1, 6, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("pre_rst_count", count, 3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_zero", zero, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_tc", tc, 0);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      check("post_rst_count", count, 0);
      check("post_rst_busy", busy, 0);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit ld, e, ar;
      int lv;
      ld = ($urandom_range(0, 9) == 0);
      lv = $urandom_range(0, MAXV);
      e  = ($urandom_range(0, 3) != 0);
      ar = ($urandom_range(0, 4) != 0);
      step(ld, lv, e, ar);
      exp_q.push_back(W'(m_count));
      check("rnd_count", count, exp_q.pop_front());
      check("rnd_tc", tc, m_tc);
      check("rnd_busy", busy, m_run);
      check("rnd_zero", zero, m_count == 0);
`ifdef DOWN_COUNTER_WRAP_CNT_EN
      check("rnd_wrap_cnt", wrap_cnt, m_wrap);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
